// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: address/control generator for a dual-port sample RAM
// that turns an incoming sample stream into a programmable-length delay line.
// Optional build macro: DELAY_LINE_FREEZE_EN adds a 'freeze' input that
// stops writing while in RUN and replays the frozen buffer on the read port.
module delay_line_ctrl #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0]    sample_in,
`ifdef DELAY_LINE_FREEZE_EN
  input  logic                     freeze,
`endif
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     dout_valid,
  output logic                     fill_done
);

  // Fill counter is one bit wider so it can reach the full buffer depth.
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] FULL_DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_next;
  logic [CW-1:0]            fill_cnt;
  logic [CW-1:0]            fill_cnt_next;
  logic [ADDRESS_WIDTH-1:0] offset_q;

  logic [CW-1:0]            offset_eff;
  logic [CW-1:0]            offset_eff_new;
  logic                     mismatch;
  logic                     freeze_active;
  logic                     do_write;
  logic                     do_read;

  logic                     wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0]    ram_din_d;
  logic                     rd_en_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_d;
  logic                     dout_valid_d;
  logic                     fill_done_d;

  // An offset of zero selects the full buffer depth.
  assign offset_eff     = (offset_q == '0) ? FULL_DEPTH : {1'b0, offset_q};
  assign offset_eff_new = (offset == '0) ? FULL_DEPTH : {1'b0, offset};
  assign mismatch       = (offset != offset_q);

`ifdef DELAY_LINE_FREEZE_EN
  assign freeze_active = freeze && (state == RUN) && !mismatch;
`else
  assign freeze_active = 1'b0;
`endif

  // A sample is written unless the buffer is frozen; reads only happen in a
  // settled RUN state (never on the cycle an offset change restarts filling).
  assign do_write = en && !freeze_active;
  assign do_read  = en && (state == RUN) && !mismatch;

  // State register: FSM state, write pointer, fill count and captured offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      offset_q <= offset;
    end else begin
      state    <= state_next;
      wr_ptr   <= wr_ptr_next;
      fill_cnt <= fill_cnt_next;
      offset_q <= offset;
    end
  end

  // Next-state logic: track how much history the buffer holds for the
  // current offset, restarting the fill whenever the offset changes.
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    wr_ptr_next   = do_write ? wr_ptr + ADDRESS_WIDTH'(1) : wr_ptr;
    if (mismatch) begin
      state_next    = FILL;
      fill_cnt_next = '0;
      if (en) begin
        fill_cnt_next = CNT_ONE;
        if (offset_eff_new == CNT_ONE) begin
          state_next = RUN;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            fill_cnt_next = CNT_ONE;
            state_next    = (offset_eff == CNT_ONE) ? RUN : FILL;
          end
        end
        FILL: begin
          if (en) begin
            fill_cnt_next = fill_cnt + CNT_ONE;
            if ((fill_cnt + CNT_ONE) == offset_eff) begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          fill_cnt_next = fill_cnt;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Output logic: next values of the registered RAM port signals. The read
  // address trails the write pointer by the effective offset, which for full
  // depth equals the write address (the RAM returns the old contents).
  always_comb begin
    wr_en_d      = do_write;
    rd_en_d      = do_read;
    wr_addr_d    = wr_addr;
    ram_din_d    = ram_din;
    rd_addr_d    = rd_addr;
    dout_valid_d = rd_en;
    fill_done_d  = (state_next == RUN);
    if (do_write) begin
      wr_addr_d = wr_ptr;
      ram_din_d = sample_in;
    end
    if (do_read) begin
      if (freeze_active) begin
        rd_addr_d = rd_addr + ADDRESS_WIDTH'(1);
      end else begin
        rd_addr_d = wr_ptr - offset_eff[ADDRESS_WIDTH-1:0];
      end
    end
  end

  // Output registers; reset also cancels any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      ram_din    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      dout_valid <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      ram_din    <= ram_din_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      dout_valid <= dout_valid_d;
      fill_done  <= fill_done_d;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Testbench for delay_line_ctrl (default build, DELAY_LINE_FREEZE_EN undefined).
// A behavioural RAM sits on the DUT ports; a sample-history model predicts
// every output and the delayed RAM data.
module tb_delay_line_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] offset;
  logic [DW-1:0] sample_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] ram_din;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          dout_valid;
  logic          fill_done;

  int errors = 0;
  int checks = 0;

  // Clock generation
  always #5 clk = ~clk;

  delay_line_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .offset    (offset),
    .sample_in (sample_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .ram_din   (ram_din),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .dout_valid(dout_valid),
    .fill_done (fill_done)
  );

  // Behavioural dual-port RAM, registered read, read-before-write
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  logic [DW-1:0] ram_dout;
  always @(posedge clk) begin
    if (rd_en) ram_dout <= ram_mem[rd_addr];
    if (wr_en) ram_mem[wr_addr] <= ram_din;
  end

  // Model: a sample read is allowed once 'offset_eff' samples have been
  // written since reset or the last offset change; the delayed value is the
  // sample written offset_eff samples ago.
  bit            model_live = 1'b0;
  int            m_wcount;
  int            m_since;
  int            m_off;
  int            m_eff;
  logic [DW-1:0] m_hist [0:4095];
  logic          exp_wr_en, exp_rd_en, exp_dv, exp_fd;
  int            exp_wr_addr, exp_rd_addr;
  logic [DW-1:0] exp_din, exp_rd_data, exp_dout_data;

  always @(posedge clk) begin
    if (rst) begin
      exp_wr_en = 0; exp_rd_en = 0; exp_dv = 0; exp_fd = 0;
      exp_wr_addr = 0; exp_rd_addr = 0; exp_din = '0;
      m_wcount = 0; m_since = 0; m_off = int'(offset);
    end else begin
      exp_dv        = exp_rd_en;
      exp_dout_data = exp_rd_data;
      if (int'(offset) != m_off) begin
        m_off   = int'(offset);
        m_since = 0;
      end
      m_eff     = (m_off == 0) ? DEPTH : m_off;
      exp_wr_en = 0;
      exp_rd_en = 0;
      if (en) begin
        exp_wr_en   = 1;
        exp_wr_addr = m_wcount % DEPTH;
        exp_din     = sample_in;
        if (m_since >= m_eff) begin
          exp_rd_en   = 1;
          exp_rd_addr = (m_wcount - m_eff) % DEPTH;
          exp_rd_data = m_hist[m_wcount - m_eff];
        end
        m_hist[m_wcount] = sample_in;
        m_wcount++;
        m_since++;
      end
      exp_fd = (m_since >= m_eff);
    end
    model_live = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [AW-1:0] o,
                               input logic [DW-1:0] s);
    rst       = r;
    en        = e;
    offset    = o;
    sample_in = s;
    @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("wr_en", wr_en, exp_wr_en);
      checkOutput("rd_en", rd_en, exp_rd_en);
      checkOutput("dout_valid", dout_valid, exp_dv);
      checkOutput("fill_done", fill_done, exp_fd);
      if (exp_wr_en) begin
        checkOutput("wr_addr", wr_addr, exp_wr_addr);
        checkOutput("ram_din", ram_din, exp_din);
      end
      if (exp_rd_en) checkOutput("rd_addr", rd_addr, exp_rd_addr);
      if (exp_dv) checkOutput("ram_dout", ram_dout, exp_dout_data);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; offset = 9'd4; sample_in = '0;
    $display("[TB] reset and idle");
    applyStimulus(1, 0, 9'd4, 0);
    applyStimulus(1, 0, 9'd4, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 9'd4, 0);
    checkOutput("idle_wr_en", wr_en, 0);
    checkOutput("idle_wr_addr", wr_addr, 0);
    checkOutput("idle_ram_din", ram_din, 0);
    checkOutput("idle_rd_en", rd_en, 0);
    checkOutput("idle_rd_addr", rd_addr, 0);
    checkOutput("idle_dout_valid", dout_valid, 0);
    checkOutput("idle_fill_done", fill_done, 0);

    $display("[TB] offset=4 stream");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 9'd4, DW'(10 + i));
      if (i == 0) begin
        checkOutput("s1_wr_en", wr_en, 1);
        checkOutput("s1_wr_addr", wr_addr, 0);
        checkOutput("s1_ram_din", ram_din, 10);
        checkOutput("s1_rd_en", rd_en, 0);
      end
      if (i == 2) checkOutput("s3_fill_done", fill_done, 0);
      if (i == 3) begin
        checkOutput("s4_fill_done", fill_done, 1);
        checkOutput("s4_rd_en", rd_en, 0);
        checkOutput("s4_wr_addr", wr_addr, 3);
      end
      if (i == 4) begin
        checkOutput("s5_rd_en", rd_en, 1);
        checkOutput("s5_rd_addr", rd_addr, 0);
        checkOutput("s5_wr_addr", wr_addr, 4);
      end
      if (i == 5) begin
        checkOutput("s6_dout_valid", dout_valid, 1);
        checkOutput("s6_ram_dout", ram_dout, 10);
      end
      if (i == 6) checkOutput("s7_ram_dout", ram_dout, 11);
      if (i == 7) checkOutput("s8_ram_dout", ram_dout, 12);
    end

    $display("[TB] en toggling in RUN");
    applyStimulus(0, 0, 9'd4, 0);
    checkOutput("tog0_wr_en", wr_en, 0);
    checkOutput("tog0_rd_en", rd_en, 0);
    applyStimulus(0, 1, 9'd4, 8'd20);
    checkOutput("tog1_wr_addr", wr_addr, 10);
    checkOutput("tog1_rd_addr", rd_addr, 6);
    applyStimulus(0, 0, 9'd4, 0);
    checkOutput("tog2_dout_valid", dout_valid, 1);
    checkOutput("tog2_ram_dout", ram_dout, 16);
    checkOutput("tog2_rd_en", rd_en, 0);
    applyStimulus(0, 1, 9'd4, 8'd21);
    checkOutput("tog3_wr_addr", wr_addr, 11);
    checkOutput("tog3_rd_addr", rd_addr, 7);
    checkOutput("tog3_dout_valid", dout_valid, 0);

    $display("[TB] offset change 4 -> 2");
    applyStimulus(0, 1, 9'd2, 8'd30);
    checkOutput("oc0_fill_done", fill_done, 0);
    checkOutput("oc0_rd_en", rd_en, 0);
    checkOutput("oc0_wr_addr", wr_addr, 12);
    checkOutput("oc0_ram_dout", ram_dout, 17);
    applyStimulus(0, 1, 9'd2, 8'd31);
    checkOutput("oc1_fill_done", fill_done, 1);
    checkOutput("oc1_rd_en", rd_en, 0);
    checkOutput("oc1_wr_addr", wr_addr, 13);
    applyStimulus(0, 1, 9'd2, 8'd32);
    checkOutput("oc2_rd_en", rd_en, 1);
    checkOutput("oc2_rd_addr", rd_addr, 12);
    applyStimulus(0, 1, 9'd2, 8'd33);
    checkOutput("oc3_ram_dout", ram_dout, 30);
    applyStimulus(0, 1, 9'd2, 8'd34);
    checkOutput("oc4_ram_dout", ram_dout, 31);
    checkOutput("oc4_rd_en", rd_en, 1);

    $display("[TB] reset after a RUN read");
    applyStimulus(1, 0, 9'd2, 0);
    checkOutput("rst_dout_valid", dout_valid, 0);
    checkOutput("rst_fill_done", fill_done, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    applyStimulus(0, 1, 9'd2, 8'd40);
    checkOutput("post_rst_wr_addr", wr_addr, 0);
    checkOutput("post_rst_rd_en", rd_en, 0);

    $display("[TB] full depth, offset=0");
    applyStimulus(1, 0, 9'd0, 0);
    for (int i = 0; i < 520; i++) begin
      applyStimulus(0, 1, 9'd0, DW'((i * 7 + 5) % 256));
      if (i == 510) checkOutput("fd511_fill_done", fill_done, 0);
      if (i == 511) begin
        checkOutput("fd512_fill_done", fill_done, 1);
        checkOutput("fd512_rd_en", rd_en, 0);
        checkOutput("fd512_wr_addr", wr_addr, 511);
      end
      if (i == 512) begin
        checkOutput("fd513_rd_en", rd_en, 1);
        checkOutput("fd513_rd_addr", rd_addr, 0);
        checkOutput("fd513_wr_addr", wr_addr, 0);
      end
      if (i == 513) begin
        checkOutput("fd514_dout_valid", dout_valid, 1);
        checkOutput("fd514_ram_dout", ram_dout, 5);
      end
      if (i == 514) checkOutput("fd515_ram_dout", ram_dout, 12);
    end
    applyStimulus(0, 0, 9'd0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Address/control generator that sits directly upstream of the team's dual-port sample RAM (9-bit address, 8-bit data, 1-cycle registered read).
- Accepts a sample stream with a strobe and produces the RAM write port signals (wr_en, wr_addr, din) and read port signals (rd_en, rd_addr).
- The RAM output is the input sample delayed by a programmable number of samples.
- Tracks buffer fill so downstream logic only uses RAM dout once it holds valid history.

Parameters:
- ADDRESS_WIDTH, 9, RAM address width; buffer depth is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8, sample width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- en  input  1  sample strobe; one sample accepted per cycle en=1.
- offset  input  ADDRESS_WIDTH  delay in samples; 0 means full depth (2**ADDRESS_WIDTH).
- sample_in  input  DATA_WIDTH  incoming sample, valid when en=1.
- wr_en  output  1  RAM write enable.
- wr_addr  output  ADDRESS_WIDTH  RAM write address.
- ram_din  output  DATA_WIDTH  RAM write data.
- rd_en  output  1  RAM read enable.
- rd_addr  output  ADDRESS_WIDTH  RAM read address.
- dout_valid  output  1  RAM dout holds a valid delayed sample this cycle.
- fill_done  output  1  level; buffer holds at least offset samples.

Behaviour:
- All outputs are registered. Reset values: wr_en=0, rd_en=0, dout_valid=0, fill_done=0, wr_addr=0, rd_addr=0, ram_din=0. Internal state after reset: wr_ptr=0, fill_cnt=0, state=IDLE, offset_q=offset.
- Latency:
  - en=1 at cycle N drives wr_en=1, wr_addr=wr_ptr and ram_din=sample_in at N+1.
  - In RUN, the same event also drives rd_en=1 and rd_addr=(wr_ptr-offset_eff) mod 2**ADDRESS_WIDTH at N+1.
  - The RAM returns data at N+2; dout_valid=1 at N+2 for exactly one cycle.
- wr_ptr increments by 1 on each accepted sample and wraps from 2**ADDRESS_WIDTH-1 to 0.
- offset_eff = offset_q, or 2**ADDRESS_WIDTH when offset_q=0. fill_cnt is ADDRESS_WIDTH+1 bits.
- Read-before-write: with offset_eff=2**ADDRESS_WIDTH, rd_addr equals wr_addr. The RAM returns the old contents, which is the required full-depth delay.
- en=0: wr_en=0 and rd_en=0 next cycle; pointers hold.
- State machine:
  - IDLE: entered on reset. The first en=1 writes and moves to FILL with fill_cnt=1.
  - FILL: each en increments fill_cnt. When the sample that makes fill_cnt==offset_eff is accepted, move to RUN and set fill_done=1. That sample is written but not read. rd_en=0 throughout FILL.
  - RUN: every en writes and reads; fill_cnt saturates.
- Offset change:
  - offset is compared with offset_q every cycle.
  - On mismatch, offset_q takes the new value, fill_cnt is cleared, fill_done=0, and the state goes to FILL. wr_ptr continues and is not reset.
  - If en=1 in the mismatch cycle, that sample is written and counts as fill_cnt=1 (not 0); no read is issued.
- rst has priority over everything, including in-flight reads. dout_valid=0 on the cycle after rst regardless of a pending read.

Optional Feature:
- Macro DELAY_LINE_FREEZE_EN.
- Defined: adds input port freeze (1 bit). While freeze=1 and state=RUN:
  - en produces rd_en only; wr_en=0.
  - rd_addr advances by 1 per en from its last value, wrapping, replaying the frozen buffer.
  - wr_ptr holds.
- On freeze falling: rd_addr realigns to wr_ptr-offset_eff on the next en; no refill.
- freeze in IDLE/FILL has no effect.
- Undefined: port absent; behaviour identical to freeze=0.

Test Plan:
- Reset then 3 idle cycles -> all outputs 0, state IDLE.
- offset=4, en=1 continuously, sample_in=10,11,12,...
  - wr_addr 0,1,2,... from cycle 1.
  - fill_done rises with the 4th sample.
  - First rd_en with 5th sample, rd_addr=0.
  - First dout_valid with RAM dout=10, then 11, 12.
- offset=0, stream 520 samples -> first read at sample 513, rd_addr=wr_addr=0, dout equals sample 1 (512-sample delay).
- offset=4 in RUN, change to 2 with en=1 -> fill_done=0 next cycle, rd_en=0 for that sample. The next sample (fill_cnt=2) reaches fill_done=1 but is not read; reads resume on the sample after, with rd_addr=wr_ptr-2.
- en toggling 1,0,1,0 in RUN -> wr_en/rd_en/dout_valid pulse every other cycle; pointers advance by 1 per accepted sample only.
- rst asserted one cycle after a RUN read -> dout_valid=0 next cycle, fill_done=0, state IDLE, wr_addr=0.
